// File: rtl/ifu_fetch.sv
// ifu_fetch: owns the PC, issues 8-byte aligned fetches and queues
// the selected 32-bit word with its PC for decode.
module ifu_fetch #(
  parameter logic [63:0] PC_RST = 64'h8000_0000,
  parameter int          DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [63:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] inst_pc
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0]   LIMIT = (CW+1)'(DEPTH);
  localparam logic [PW-1:0] LAST  = PW'(DEPTH - 1);

  logic [63:0]   r_fetch_pc;
  logic          r_run;
  logic [CW-1:0] r_inflight;
  logic [CW-1:0] r_drop;
  logic [CW-1:0] r_icnt;
  logic [63:0]   r_tag_pc [DEPTH];
  logic [PW-1:0] r_tag_wr;
  logic [PW-1:0] r_tag_rd;
  logic [63:0]   r_ipc [DEPTH];
  logic [31:0]   r_iword [DEPTH];
  logic [PW-1:0] r_iwr;
  logic [PW-1:0] r_ird;

  logic          w_req_fire;
  logic          w_resp;
  logic          w_keep;
  logic          w_pop;
  logic [63:0]   w_tag_pc;
  logic [31:0]   w_word;
  logic [CW:0]   w_used;
  logic [CW-1:0] w_outstanding;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  // Credit covers both in-flight requests and buffered words
  assign w_used         = {1'b0, r_inflight} + {1'b0, r_icnt};
  assign imem_req_valid = r_run & (w_used < LIMIT);
  assign imem_req_addr  = r_fetch_pc & ~64'h7;
  assign w_req_fire     = imem_req_valid & imem_req_ready;
  assign w_resp         = imem_resp_valid & (r_inflight != '0);
  assign w_tag_pc       = r_tag_pc[r_tag_rd];
  assign w_word         = w_tag_pc[2] ? imem_resp_data[63:32]
                                      : imem_resp_data[31:0];
  assign w_keep         = w_resp & (r_drop == '0) & ~redirect_valid;
  assign w_outstanding  = r_inflight + CW'(w_req_fire) - CW'(w_resp);
  assign inst_valid     = (r_icnt != '0);
  assign w_pop          = inst_valid & inst_ready;
  assign inst           = r_iword[r_ird];
  assign inst_pc        = r_ipc[r_ird];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= PC_RST;
      r_run      <= 1'b0;
      r_inflight <= '0;
      r_drop     <= '0;
      r_icnt     <= '0;
      r_tag_wr   <= '0;
      r_tag_rd   <= '0;
      r_iwr      <= '0;
      r_ird      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_tag_pc[i] <= '0;
        r_ipc[i]    <= '0;
        r_iword[i]  <= '0;
      end
    end else begin
      r_run      <= 1'b1;
      r_inflight <= w_outstanding;
      if (w_req_fire) begin
        r_tag_pc[r_tag_wr] <= r_fetch_pc;
        r_tag_wr           <= f_inc(r_tag_wr);
      end
      if (w_resp) r_tag_rd <= f_inc(r_tag_rd);
      if (w_keep) begin
        r_ipc[r_iwr]   <= w_tag_pc;
        r_iword[r_iwr] <= w_word;
      end
      // Everything still outstanding after a redirect is stale
      if (redirect_valid) begin
        r_fetch_pc <= redirect_pc & ~64'h3;
        r_drop     <= w_outstanding;
        r_icnt     <= '0;
        r_iwr      <= '0;
        r_ird      <= '0;
      end else begin
        if (w_req_fire) r_fetch_pc <= r_fetch_pc + 64'd4;
        if (w_resp && (r_drop != '0)) r_drop <= r_drop - CW'(1);
        if (w_keep) r_iwr <= f_inc(r_iwr);
        if (w_pop) r_ird <= f_inc(r_ird);
        r_icnt <= r_icnt + CW'(w_keep) - CW'(w_pop);
      end
    end
  end

  a_no_orphan_resp: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_resp_valid && (r_inflight == '0)));
  a_drop_bound: assert property (@(posedge clk) disable iff (!rst_n)
    r_drop <= r_inflight);

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch unit: the requesting end of the instruction-memory interface. It owns the PC, issues 8-byte-aligned fetch requests to instruction memory and receives 64-bit responses. It extracts the 32-bit instruction selected by pc[2] (low word when pc[2]=0, high word when pc[2]=1) and queues it with its PC for decode on a valid/ready channel. It sits between the instruction memory and the decode stage, and takes redirects from execute/commit.

## Interface
- PC_RST, 64'h8000_0000, PC value loaded at reset.
- DEPTH, 4, maximum in-flight requests plus buffered instructions; must be ≥ 2.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- redirect_valid  input  1  load a new PC and flush.
- redirect_pc  input  64  new PC; bits [1:0] are ignored and treated as 0.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts the request.
- imem_req_addr  output  64  fetch_pc & ~64'h7.
- imem_resp_valid  input  1  response valid; always accepted, no ready.
- imem_resp_data  input  64  fetched 8-byte word.
- inst_valid  output  1  instruction available to decode.
- inst_ready  input  1  decode accepts the instruction.
- inst  output  32  instruction word.
- inst_pc  output  64  PC of inst.

## Operation
- State:
  - fetch_pc (64)
  - run flag
  - inflight counter
  - drop counter
  - tag FIFO: DEPTH entries of pc[2] plus the PC of each outstanding request
  - instruction FIFO: DEPTH entries of {pc, inst}
- Credit rule: imem_req_valid = run & (inflight + inst_count < DEPTH). Counts are taken before this cycle's pop, which is conservative, so the instruction FIFO can never overflow.
- Request fire (valid & ready):
  - push fetch_pc into the tag FIFO;
  - fetch_pc += 4, wrapping modulo 2^64;
  - inflight += 1.
- Response: responses arrive in order, no earlier than the cycle after their request fires, never more than inflight. On each response:
  - pop the tag FIFO and decrement inflight;
  - if drop > 0, decrement drop and discard the data;
  - otherwise push {tag_pc, tag_pc[2] ? data[63:32] : data[31:0]} into the instruction FIFO.
- Decode side: inst_valid = instruction FIFO not empty; inst and inst_pc come from the FIFO head. The head pops on inst_valid & inst_ready.
- Redirect, effective at the clock edge:
  - fetch_pc ← {redirect_pc[63:2], 2'b00};
  - the instruction FIFO is emptied;
  - drop ← inflight + req_fire − resp_fire, so every request still outstanding after this cycle is discarded;
  - a response arriving in the redirect cycle is discarded;
  - a pop in the redirect cycle is still a valid handshake.
- Simultaneous request fire and redirect: the request is issued with the old fetch_pc, counted into drop, and its data is discarded.
- Back-to-back redirects: the later redirect's drop value supersedes the earlier one; the formula already counts everything outstanding.
- Back-pressure: with inst_ready low, requests stop once inflight + inst_count = DEPTH. No instruction is lost or reordered.
- drop never exceeds inflight. A response arriving with inflight = 0 is a protocol violation: assert in simulation, otherwise ignored.

## Timing
- Reset values, while rst_n is low:
  - fetch_pc = PC_RST, run = 0, inflight = 0, drop = 0, both FIFOs empty;
  - imem_req_valid = 0, inst_valid = 0, imem_req_addr = PC_RST & ~7, inst = 0, inst_pc = 0.
- Start-up: run is set at the first rising edge with rst_n high. imem_req_valid first rises in the following cycle.
- Latency, with request firing at cycle N and the response at N+k: inst_valid is high at cycle N+k+1. Minimum is 2 cycles from request to decode.
- Throughput: sustained 1 instruction/cycle with 1-cycle memory, inst_ready held high and DEPTH ≥ 3.
- Outputs:
  - imem_req_valid and imem_req_addr are combinational from registered state only, with no dependence on imem_req_ready.
  - inst_valid, inst and inst_pc come directly from FIFO registers.
- Redirect: the first request to the new PC is issued in the cycle after redirect_valid. Its instruction reaches decode no earlier than 2 cycles after that request fires.
- Reset asserted mid-operation returns all state to reset values immediately, dropping FIFO contents and in-flight tracking. The memory model must also be reset.

## Test plan
- Reset to streaming: hold rst_n low 3 cycles, then high; 1-cycle memory returning word index as data; inst_ready = 1.
  - Required: requests at addresses 0x8000_0000, 0x8000_0000, 0x8000_0008, 0x8000_0008, …
  - Required: decode receives PCs 0x8000_0000, 0x8000_0004, 0x8000_0008 with the correct low/high halves, one per cycle after the first.
- Half-select: memory word 0x1111_2222_3333_4444 at 0x8000_0000.
  - Required: inst_pc 0x8000_0000 gives inst 0x3333_4444.
  - Required: inst_pc 0x8000_0004 gives inst 0x1111_2222.
- Back-pressure: inst_ready = 0 for 20 cycles.
  - Required: exactly DEPTH instructions are buffered or in flight and imem_req_valid drops to 0.
  - Required: on release, the sequence continues gap-free and in order.
- Redirect with in-flight requests: 3-cycle memory latency, redirect to 0x8000_0100 while 2 requests are outstanding.
  - Required: both stale responses are discarded.
  - Required: the next inst_pc is 0x8000_0100 and no PC below it appears afterwards.
- Redirect coinciding with a response and a request fire: redirect_pc 0x8000_0042.
  - Required: the response and the new request are dropped.
  - Required: the next inst_pc is 0x8000_0040.
- Random latency (1–5 cycles), random inst_ready and periodic redirects over 10k cycles.
  - Required: decode output matches a golden PC-sequence model.
  - Required: inflight + inst_count never exceeds DEPTH, and no response arrives with inflight = 0.
